button_conditioner: RTL and testbench
=====================================

# button_conditioner

Input-side conditioning for the five front-panel push-buttons (up, down, left, right, middle). Each raw pin passes through a synchroniser, a debouncer and an edge detector, producing one-cycle press pulses and clean held levels. These pulses are consumed by mode selection, the alarm and time-setting logic, in place of the raw pins. Up/down can auto-repeat while held, and middle reports a separate long-press event.

## Interface
- DEBOUNCE_CYCLES, 20'd500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz).
- LONG_CYCLES, 27'd75000000: accepted-press duration on middle that fires `middle_long` (1.5 s).
- REPEAT_DELAY_CYCLES, 26'd25000000: hold time before the first auto-repeat on up/down.
- REPEAT_RATE_CYCLES, 24'd5000000: interval between subsequent auto-repeats.
- clk  in  1  system clock, same clock as the rest of the clock design.
- rst_n  in  1  asynchronous, active-low reset.
- btn_raw  in  5  raw pins, active-high; bit order {middle,right,left,down,up} = [4:0].
- btn_held  out  5  debounced level, same bit order.
- btn_press  out  5  one-cycle pulse per accepted press (including auto-repeats on up/down).
- btn_release  out  5  one-cycle pulse per accepted release.
- middle_long  out  1  one-cycle pulse on the long-press threshold of middle.

## Operation
- Reset: every output is 0, synchronisers are 0, all counters are 0, and every channel FSM is in IDLE.
- Sync: two flops per bit. Debouncing only ever sees `sync[i]`.
- Per-channel FSM states:
  - IDLE: held=0. Leaves when sync=1.
  - DEB_ON: counts up while sync=1. When the count reaches DEBOUNCE_CYCLES-1, go to PRESSED. If sync=0 first, clear the count and return to IDLE.
  - PRESSED: held=1. Leaves when sync=0.
  - DEB_OFF: mirror of DEB_ON. On success, go to IDLE. A glitch back to 1 returns to PRESSED.
- Pulses:
  - `btn_press[i]` is 1 on the cycle the FSM enters PRESSED from DEB_ON.
  - `btn_release[i]` is 1 on the cycle it enters IDLE from DEB_OFF.
  - Presses and releases always alternate, never two of the same in a row.
- Long press:
  - The hold counter on middle starts at 0 on entry to PRESSED and saturates.
  - `middle_long` pulses once when the counter equals LONG_CYCLES-1.
  - A release before that threshold gives no long pulse. The normal press pulse still fires at press time.
- Auto-repeat (up/down only, see Configuration):
  - A repeat counter starts at 0 on entry to PRESSED.
  - At REPEAT_DELAY_CYCLES-1, `btn_press` pulses and the counter reloads to 0.
  - From then on, a pulse fires every REPEAT_RATE_CYCLES while still PRESSED.
  - Entering DEB_OFF freezes the counter. Returning to PRESSED after a release glitch resumes it with no extra pulse.
- Channels are fully independent. Simultaneous presses on several buttons yield simultaneous pulses in the same cycle.
- Reset asserted mid-debounce or mid-hold clears everything immediately. No release pulse is generated for a button held across reset.
- Counters saturate and never wrap, so a button held indefinitely produces no spurious events.

## Timing
- A clean raw rise sampled at edge 0 gives `btn_held`=1 and `btn_press`=1 after edge DEBOUNCE_CYCLES+2: 2 cycles of sync plus DEBOUNCE_CYCLES of count.
- A release follows the same rule: the release pulse comes DEBOUNCE_CYCLES+2 edges after raw falls.
- All outputs are registered. There is no combinational path from `btn_raw`.
- First auto-repeat comes REPEAT_DELAY_CYCLES after the initial press pulse. Later repeats are spaced exactly REPEAT_RATE_CYCLES apart.
- `middle_long` comes LONG_CYCLES after the middle press pulse.

## Configuration
- BTN_AUTOREPEAT_EN defined: the auto-repeat logic is present on the up and down channels.
- BTN_AUTOREPEAT_EN undefined:
  - No repeat counters are synthesised.
  - `btn_press` fires exactly once per accepted press on every channel.
  - REPEAT_* parameters are ignored.
- Long press on middle is always present regardless of the macro.

## Structure
- Shared package `btn_pkg` holds:
  - the channel FSM state enum (IDLE, DEB_ON, PRESSED, DEB_OFF);
  - button index constants BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3, BTN_MID=4.
- One sub-module, `btn_channel`, contains sync + FSM + debounce counter, with parameter-enabled hold and repeat counters.
- The top level instantiates five copies and enables:
  - repeat on channels 0 and 1;
  - long press on channel 4.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=40, REPEAT_DELAY_CYCLES=20, REPEAT_RATE_CYCLES=8.
- Reset: drive rst_n=0 with all raw=1. All outputs must stay 0 throughout reset. After rst_n rises, press pulses fire on all 5 bits in the same cycle, 6 edges later.
- Bounce: toggle up raw 1,0,1,0 every 2 cycles, then hold at 1. Exactly one press, arriving 6 edges after the final rise; held=1.
- Clean release: release left after 10 cycles held. One release pulse 6 edges after the fall; held=0.
- Release glitch: hold down, then apply a 2-cycle low glitch. No release pulse and no extra press.
- Auto-repeat (macro on): hold up for 60 cycles after acceptance. Press pulses at t=0, 20, 28, 36, 44, 52. With the macro off, only t=0.
- Long press: hold middle for 50 cycles. One press, then `middle_long` at 40. Releasing at 30 instead gives no `middle_long`.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and constants for the front-panel push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DEB_ON  = 2'd1,
    PRESSED = 2'd2,
    DEB_OFF = 2'd3
  } btn_state_t;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_MID   = 4;
  localparam int BTN_COUNT = 5;

endpackage

// File: rtl/btn_channel.sv
// One button: two-flop synchroniser, debounce FSM, registered pulses, and
// optional hold (long-press) and auto-repeat counters selected by parameter.
module btn_channel
  import btn_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES     = 20'd500000,
  parameter logic [26:0] LONG_CYCLES         = 27'd75000000,
  parameter logic [25:0] REPEAT_DELAY_CYCLES = 26'd25000000,
  parameter logic [23:0] REPEAT_RATE_CYCLES  = 24'd5000000,
  parameter bit          LONG_EN             = 1'b0,
  parameter bit          REPEAT_EN           = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic held,
  output logic press,
  output logic release_pulse,
  output logic long_pulse
);

  localparam logic [19:0] DEB_LIM = DEBOUNCE_CYCLES - 20'd1;

  logic [1:0]  sync_r;
  logic        in_s;
  btn_state_t  state_r;
  btn_state_t  state_next_s;
  logic [19:0] deb_cnt_r;
  logic        deb_inc_s;
  logic        deb_clr_s;
  logic        deb_at_lim_s;
  logic        press_s;
  logic        release_s;
  logic        rep_fire_s;
  logic        long_fire_s;

  assign in_s         = sync_r[1];
  assign deb_at_lim_s = (deb_cnt_r == DEB_LIM);

  // Synchroniser for the asynchronous pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], raw};
    end
  end

  // Channel state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state, debounce counter control and press/release detection
  always_comb begin
    state_next_s = state_r;
    deb_inc_s    = 1'b0;
    deb_clr_s    = 1'b0;
    press_s      = 1'b0;
    release_s    = 1'b0;
    case (state_r)
      IDLE: begin
        deb_clr_s = 1'b1;
        if (in_s) begin
          state_next_s = DEB_ON;
        end else begin
          state_next_s = IDLE;
        end
      end
      DEB_ON: begin
        if (!in_s) begin
          deb_clr_s    = 1'b1;
          state_next_s = IDLE;
        end else if (deb_at_lim_s) begin
          deb_clr_s    = 1'b1;
          press_s      = 1'b1;
          state_next_s = PRESSED;
        end else begin
          deb_inc_s    = 1'b1;
          state_next_s = DEB_ON;
        end
      end
      PRESSED: begin
        deb_clr_s = 1'b1;
        if (!in_s) begin
          state_next_s = DEB_OFF;
        end else begin
          state_next_s = PRESSED;
        end
      end
      DEB_OFF: begin
        if (in_s) begin
          deb_clr_s    = 1'b1;
          state_next_s = PRESSED;
        end else if (deb_at_lim_s) begin
          deb_clr_s    = 1'b1;
          release_s    = 1'b1;
          state_next_s = IDLE;
        end else begin
          deb_inc_s    = 1'b1;
          state_next_s = DEB_OFF;
        end
      end
      default: begin
        deb_clr_s    = 1'b1;
        state_next_s = IDLE;
      end
    endcase
  end

  // Debounce counter; bounded by DEB_LIM so it cannot wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_r <= 20'd0;
    end else if (deb_clr_s) begin
      deb_cnt_r <= 20'd0;
    end else if (deb_inc_s) begin
      deb_cnt_r <= deb_cnt_r + 20'd1;
    end else begin
      deb_cnt_r <= deb_cnt_r;
    end
  end

  if (REPEAT_EN) begin : g_repeat
    localparam logic [25:0] DELAY_LIM = REPEAT_DELAY_CYCLES - 26'd1;
    localparam logic [25:0] RATE_LIM  = {2'b00, REPEAT_RATE_CYCLES - 24'd1};

    logic [25:0] rep_cnt_r;
    logic        rep_first_r;
    logic        rep_run_s;
    logic [25:0] rep_lim_s;

    // Counting only while steadily pressed freezes it across a release glitch.
    assign rep_run_s  = (state_r == PRESSED) && in_s;
    assign rep_lim_s  = rep_first_r ? DELAY_LIM : RATE_LIM;
    assign rep_fire_s = rep_run_s && (rep_cnt_r == rep_lim_s);

    // Repeat interval counter, restarted by every accepted press
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rep_cnt_r   <= 26'd0;
        rep_first_r <= 1'b1;
      end else if (press_s) begin
        rep_cnt_r   <= 26'd0;
        rep_first_r <= 1'b1;
      end else if (rep_fire_s) begin
        rep_cnt_r   <= 26'd0;
        rep_first_r <= 1'b0;
      end else if (rep_run_s) begin
        rep_cnt_r   <= rep_cnt_r + 26'd1;
        rep_first_r <= rep_first_r;
      end else begin
        rep_cnt_r   <= rep_cnt_r;
        rep_first_r <= rep_first_r;
      end
    end
  end else begin : g_no_repeat
    assign rep_fire_s = 1'b0;
  end

  if (LONG_EN) begin : g_long
    localparam logic [26:0] LONG_LIM = LONG_CYCLES - 27'd1;

    logic [26:0] hold_cnt_r;

    assign long_fire_s = (state_r == PRESSED) && (hold_cnt_r == LONG_LIM);

    // Hold duration counter; parks at LONG_CYCLES so the pulse fires once
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_cnt_r <= 27'd0;
      end else if (press_s) begin
        hold_cnt_r <= 27'd0;
      end else if ((state_r == PRESSED) && (hold_cnt_r != LONG_CYCLES)) begin
        hold_cnt_r <= hold_cnt_r + 27'd1;
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end
    end
  end else begin : g_no_long
    assign long_fire_s = 1'b0;
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held          <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      held          <= (state_next_s == PRESSED) || (state_next_s == DEB_OFF);
      press         <= press_s | rep_fire_s;
      release_pulse <= release_s;
      long_pulse    <= long_fire_s;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Five-button front-panel conditioner. Define BTN_AUTOREPEAT_EN to add
// auto-repeat on the up and down buttons; middle always reports long press.
module button_conditioner
  import btn_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES     = 20'd500000,
  parameter logic [26:0] LONG_CYCLES         = 27'd75000000,
  parameter logic [25:0] REPEAT_DELAY_CYCLES = 26'd25000000,
  parameter logic [23:0] REPEAT_RATE_CYCLES  = 24'd5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn_raw,
  output logic [4:0] btn_held,
  output logic [4:0] btn_press,
  output logic [4:0] btn_release,
  output logic       middle_long
);

`ifdef BTN_AUTOREPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic [4:0] long_s;

  for (genvar i = 0; i < BTN_COUNT; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .LONG_CYCLES         (LONG_CYCLES),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES),
      .LONG_EN             (i == BTN_MID),
      .REPEAT_EN           (REPEAT_ON && ((i == BTN_UP) || (i == BTN_DOWN)))
    ) u_channel (
      .clk           (clk),
      .rst_n         (rst_n),
      .raw           (btn_raw[i]),
      .held          (btn_held[i]),
      .press         (btn_press[i]),
      .release_pulse (btn_release[i]),
      .long_pulse    (long_s[i])
    );
  end

  // Only the middle channel has a hold counter; the other bits are tied low.
  assign middle_long = |long_s;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner with short timing
// parameters (debounce 4, long 40, repeat delay 20, repeat rate 8).
module tb_button_conditioner;
  import btn_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn_raw = 5'd0;
  logic [4:0] btn_held;
  logic [4:0] btn_press;
  logic [4:0] btn_release;
  logic       middle_long;

  int errors = 0;
  int checks = 0;

  int n_press, n_rel, n_long;
  int t_press[16];
  int t_rel, t_long;

`ifdef BTN_AUTOREPEAT_EN
  int exp_n = 6;
`else
  int exp_n = 1;
`endif
  int exp_t[6] = '{0, 20, 28, 36, 44, 52};

  button_conditioner #(
    .DEBOUNCE_CYCLES     (20'd4),
    .LONG_CYCLES         (27'd40),
    .REPEAT_DELAY_CYCLES (26'd20),
    .REPEAT_RATE_CYCLES  (24'd8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .btn_held    (btn_held),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .middle_long (middle_long)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run n cycles, recording pulses on bit b (times are 1-based step indices).
  task automatic watch(input int cycles, input int b);
    n_press = 0; n_rel = 0; n_long = 0;
    t_rel = -1; t_long = -1;
    for (int c = 1; c <= cycles; c++) begin
      step();
      if (btn_press[b]) begin
        if (n_press < 16) t_press[n_press] = c;
        n_press++;
      end
      if (btn_release[b]) begin
        t_rel = c;
        n_rel++;
      end
      if (middle_long) begin
        t_long = c;
        n_long++;
      end
    end
  endtask

  initial begin
    // Reset held low with every button pressed: outputs stay quiet
    rst_n = 1'b0;
    btn_raw = 5'h1F;
    for (int c = 0; c < 4; c++) begin
      step();
      check_eq("reset_quiet", 32'({btn_held, btn_press, btn_release, middle_long}), 32'd0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check_eq("rst_press_early", 32'(btn_press), 32'd0);
    end
    step();
    check_eq("rst_press_all", 32'(btn_press), 32'h1F);
    check_eq("rst_held_all", 32'(btn_held), 32'h1F);
    step();
    check_eq("rst_press_one_cycle", 32'(btn_press), 32'd0);

    btn_raw = 5'h00;
    for (int c = 0; c < 6; c++) step();
    check_eq("rel_all_early", 32'(btn_release), 32'd0);
    step();
    check_eq("rel_all", 32'(btn_release), 32'h1F);
    check_eq("rel_all_held", 32'(btn_held), 32'd0);
    repeat (4) step();

    // Bounce on up: 1,0,1,0 for two cycles each, final rise at c=8
    n_press = 0;
    t_press[0] = -1;
    for (int c = 0; c < 18; c++) begin
      btn_raw[BTN_UP] = (c >= 8) || ((c % 4) < 2);
      step();
      if (btn_press[BTN_UP]) begin
        if (n_press < 16) t_press[n_press] = c;
        n_press++;
      end
    end
    check_eq("bounce_count", 32'(n_press), 32'd1);
    check_eq("bounce_time", 32'(t_press[0]), 32'd14);
    check_eq("bounce_held", 32'(btn_held[BTN_UP]), 32'd1);
    btn_raw[BTN_UP] = 1'b0;
    watch(8, BTN_UP);
    check_eq("bounce_release", 32'(n_rel), 32'd1);

    // Clean release on left after a 10-cycle hold
    btn_raw[BTN_LEFT] = 1'b1;
    watch(7, BTN_LEFT);
    check_eq("left_press", 32'(n_press), 32'd1);
    check_eq("left_press_time", 32'(t_press[0]), 32'd7);
    watch(10, BTN_LEFT);
    check_eq("left_hold_no_rel", 32'(n_rel), 32'd0);
    btn_raw[BTN_LEFT] = 1'b0;
    watch(10, BTN_LEFT);
    check_eq("left_rel_count", 32'(n_rel), 32'd1);
    check_eq("left_rel_time", 32'(t_rel), 32'd7);
    check_eq("left_rel_no_press", 32'(n_press), 32'd0);
    check_eq("left_held_low", 32'(btn_held[BTN_LEFT]), 32'd0);

    // Two-cycle low glitch on a held down button
    btn_raw[BTN_DOWN] = 1'b1;
    watch(12, BTN_DOWN);
    check_eq("down_press", 32'(n_press), 32'd1);
    btn_raw[BTN_DOWN] = 1'b0;
    step();
    step();
    btn_raw[BTN_DOWN] = 1'b1;
    watch(10, BTN_DOWN);
    check_eq("glitch_no_rel", 32'(n_rel), 32'd0);
    check_eq("glitch_no_press", 32'(n_press), 32'd0);
    check_eq("glitch_held", 32'(btn_held[BTN_DOWN]), 32'd1);
    btn_raw[BTN_DOWN] = 1'b0;
    watch(8, BTN_DOWN);
    check_eq("down_rel", 32'(n_rel), 32'd1);

    // Auto-repeat on up: 60 cycles past acceptance
    btn_raw[BTN_UP] = 1'b1;
    watch(66, BTN_UP);
    check_eq("repeat_count", 32'(n_press), 32'(exp_n));
    for (int k = 0; k < exp_n; k++) begin
      if (k < n_press) begin
        check_eq("repeat_time", 32'(t_press[k] - t_press[0]), 32'(exp_t[k]));
      end else begin
        check_eq("repeat_missing", 32'(n_press), 32'(exp_n));
      end
    end
    check_eq("repeat_first_time", 32'(t_press[0]), 32'd7);
    btn_raw[BTN_UP] = 1'b0;
    watch(12, BTN_UP);
    check_eq("repeat_rel", 32'(n_rel), 32'd1);

    // Long press on middle held 50 cycles
    btn_raw[BTN_MID] = 1'b1;
    watch(52, BTN_MID);
    check_eq("mid_press_count", 32'(n_press), 32'd1);
    check_eq("mid_press_time", 32'(t_press[0]), 32'd7);
    check_eq("mid_long_count", 32'(n_long), 32'd1);
    check_eq("mid_long_time", 32'(t_long - t_press[0]), 32'd40);
    btn_raw[BTN_MID] = 1'b0;
    watch(10, BTN_MID);
    check_eq("mid_rel", 32'(n_rel), 32'd1);
    check_eq("mid_rel_no_long", 32'(n_long), 32'd0);

    // Middle released 30 cycles after acceptance: no long pulse
    btn_raw[BTN_MID] = 1'b1;
    watch(37, BTN_MID);
    check_eq("short_press", 32'(n_press), 32'd1);
    check_eq("short_no_long_hold", 32'(n_long), 32'd0);
    btn_raw[BTN_MID] = 1'b0;
    watch(20, BTN_MID);
    check_eq("short_no_long_rel", 32'(n_long), 32'd0);
    check_eq("short_rel", 32'(n_rel), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
